key_event_ctrl: RTL and testbench
=================================

Name: key_event_ctrl

Overview:
- Scheduler between the keypad front end (16-bit sticky pending vector plus clear strobe) and the CPU-side event reader.
- Snapshots the pending-key vector, then issues one clear pulse back to the keypad register.
- Serialises simultaneously pending keys with a round-robin grant into a FIFO of 4-bit key codes.
- Raises a level interrupt while the FIFO occupancy is at or above a threshold.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- IRQ_THRESH, 1, occupancy at which irq asserts; range 1..DEPTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  allows new snapshots; an ENCODE already in progress always completes.
- key_data  in  16  sticky pending-key vector from the keypad register.
- key_clear  out  1  one-cycle registered clear strobe to the keypad register.
- rd_en  in  1  pops the FIFO head.
- rd_data  out  4  head key code; valid while empty=0.
- empty  out  1  FIFO empty.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- irq  out  1  count >= IRQ_THRESH.
- ovf  out  1  sticky flag: an event was dropped.
- ovf_clr  in  1  clears ovf.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - state=IDLE, pend=0, rr_ptr=15, key_clear=0, FIFO pointers=0.
  - Outputs: count=0, empty=1, rd_data=0, irq=0, ovf=0, busy=0.
- IDLE -> ENCODE when enable=1 and key_data != 0. On that edge:
  - pend <= key_data.
  - key_clear <= 1 for exactly the next cycle.
- ENCODE, each cycle:
  - Grant = first set bit of pend, searching upward from rr_ptr+1 mod 16 with wrap.
  - At the edge: push the grant index, clear that bit in pend, rr_ptr <= grant.
  - Exit to IDLE on the edge where the last set bit of pend is cleared.
- Round-robin pointer: rr_ptr persists across snapshots, so the starting key rotates. After reset the first search starts at key 0.
- Latency:
  - key_data nonzero in IDLE at cycle t -> key_clear=1 at t+1.
  - First code written at the end of t+1; empty=0 from t+2.
  - N pending keys take N ENCODE cycles.
- Full FIFO:
  - A push while full and rd_en=0 drops the code and sets ovf.
  - The pend bit still clears, so ENCODE never stalls.
  - Push with rd_en=1 while full succeeds; count is unchanged.
- Empty FIFO: rd_en while empty is ignored. No pointer move, no underflow.
- Simultaneous push and pop on a non-empty FIFO: count is unchanged.
- ovf_clr and a new drop in the same cycle: set wins.
- rd_data is combinational from the head entry, and reads 0 when empty.
- count is registered. irq is a combinational compare of registered count, so it is glitch-free.
- Keys arriving in key_data after the snapshot edge are not in pend. Whether they survive the key_clear strobe is defined by the keypad register. This block re-snapshots on the next IDLE cycle with key_data != 0.
- Reset asserted in any state: all contents lost, outputs return to reset values next cycle. No key_clear is emitted.

Decomposition:
- Shared package key_pkg holds:
  - KEY_NUM=16 and KEY_CODE_W=4.
  - State encoding IDLE=0, ENCODE=1.
- One sub-module, rr_pick16: combinational rotate-and-priority-encode.
  - Inputs: pend[15:0], rr_ptr[3:0].
  - Outputs: grant[3:0], any.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset, then key_data=16'h0004 held for one cycle with enable=1:
  - key_clear pulses one cycle.
  - rd_data=4'h2, count=1, irq=1 at t+2.
  - busy drops at t+2.
- key_data=16'h8101 with rr_ptr=15 after reset:
  - Codes 0, 8, 15 pushed on consecutive cycles; rr_ptr ends at 15.
  - A following snapshot of 16'h0003 yields 0 then 1.
- Round-robin: after grant 8, snapshot 16'h0301 -> order 9, 0, 8.
- DEPTH=8 pre-filled to 7, then key_data=16'h000F with no reads:
  - Only code 0 stored; count=8.
  - ovf=1 after the second code; 1, 2, 3 dropped.
  - ovf_clr clears ovf. ovf_clr on the same cycle as a drop keeps ovf=1.
- Full FIFO with rd_en=1 on the cycle a code pushes:
  - count stays 8, ovf stays 0, order preserved.
  - rd_en on an empty FIFO leaves count=0.
- rst asserted during ENCODE with 3 bits left in pend:
  - Next cycle busy=0, count=0, key_clear=0.
  - enable=0 with key_data nonzero -> no key_clear and no push.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and FSM encoding for the keypad event scheduler.
package key_pkg;

    localparam int unsigned KEY_NUM    = 16;
    localparam int unsigned KEY_CODE_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ENCODE = 1'b1
    } state_t;

endpackage

// File: rtl/key_event_ctrl_rr_pick16.sv
// Round-robin pick over 16 pending keys: first set bit strictly after rr_ptr, wrapping.
module rr_pick16
    import key_pkg::*;
(
    input  logic [KEY_NUM-1:0]    pend,
    input  logic [KEY_CODE_W-1:0] rr_ptr,
    output logic [KEY_CODE_W-1:0] grant,
    output logic                  any
);

    logic [KEY_CODE_W-1:0] w_idx;
    logic                  w_found;

    // Offset 16 truncates to rr_ptr itself, so the previous grant is searched last.
    always_comb begin
        grant   = '0;
        any     = |pend;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned i = 1; i <= KEY_NUM; i++) begin
            w_idx = rr_ptr + KEY_CODE_W'(i);
            if (!w_found && pend[w_idx]) begin
                grant   = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Snapshots the sticky keypad vector, clears it, and serialises pending keys
// round-robin into a key-code FIFO with threshold interrupt and sticky overflow.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned IRQ_THRESH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [KEY_NUM-1:0]      key_data,
    output logic                    key_clear,
    input  logic                    rd_en,
    output logic [KEY_CODE_W-1:0]   rd_data,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    irq,
    output logic                    ovf,
    input  logic                    ovf_clr,
    output logic                    busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    state_t                r_state;
    state_t                w_next;
    logic [KEY_NUM-1:0]    r_pend;
    logic [KEY_CODE_W-1:0] r_rr_ptr;
    logic                  r_key_clear;
    logic [KEY_CODE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovf;

    logic [KEY_CODE_W-1:0] w_grant;
    logic                  w_any;
    logic [KEY_NUM-1:0]    w_pend_after;
    logic                  w_snap;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_drop;

    rr_pick16 u_pick (
        .pend   (r_pend),
        .rr_ptr (r_rr_ptr),
        .grant  (w_grant),
        .any    (w_any)
    );

    assign w_pend_after = r_pend & ~(KEY_NUM'(1) << w_grant);
    assign w_snap       = (r_state == IDLE) && enable && (|key_data);
    assign w_push       = (r_state == ENCODE) && w_any;
    assign w_pop        = rd_en && (r_count != '0);
    assign w_full       = (r_count == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push_ok    = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_snap) w_next = ENCODE;
            ENCODE:  if (!w_any || (w_pend_after == '0)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == ENCODE);
        key_clear = r_key_clear;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= '0;
            r_rr_ptr    <= '1;
            r_key_clear <= 1'b0;
        end else begin
            r_key_clear <= w_snap;
            if (w_snap) begin
                r_pend <= key_data;
            end else if (w_push) begin
                r_pend   <= w_pend_after;
                r_rr_ptr <= w_grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];
    assign irq     = (r_count >= CW'(IRQ_THRESH));
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Randomised and directed bench for key_event_ctrl against a queue-based reference model.
module tb_key_event_ctrl;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned THRESH = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] key_data = '0;
    logic        key_clear;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_data;
    logic        empty;
    logic [3:0]  count;
    logic        irq;
    logic        ovf;
    logic        ovf_clr = 1'b0;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    key_event_ctrl #(.DEPTH(DEPTH), .IRQ_THRESH(THRESH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .key_data  (key_data),
        .key_clear (key_clear),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .count     (count),
        .irq       (irq),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO queue, a queue of codes still to be encoded, the
    // last granted key, the sticky overflow bit and the pending clear strobe.
    int m_fifo[$];
    int m_enc[$];
    int m_rr  = 15;
    bit m_ovf = 1'b0;
    bit m_kc  = 1'b0;

    always @(posedge clk) begin : model
        bit busy_now;
        bit kc;
        bit drop;
        int code;
        if (rst) begin
            m_fifo.delete();
            m_enc.delete();
            m_rr  = 15;
            m_ovf = 1'b0;
            m_kc  = 1'b0;
        end else begin
            busy_now = (m_enc.size() > 0);
            kc       = !busy_now && enable && (key_data != 16'h0);
            drop     = 1'b0;
            if (rd_en && m_fifo.size() > 0) void'(m_fifo.pop_front());
            if (busy_now) begin
                code = m_enc.pop_front();
                m_rr = code;
                if (m_fifo.size() < DEPTH) m_fifo.push_back(code);
                else                       drop = 1'b1;
            end
            if (drop)         m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (kc) begin
                for (int k = 1; k <= 16; k++) begin
                    int idx;
                    idx = (m_rr + k) % 16;
                    if (key_data[idx]) m_enc.push_back(idx);
                end
            end
            m_kc = kc;
        end
    end

    always @(negedge clk) begin : compare
        chk("count",     int'(count),     m_fifo.size());
        chk("empty",     int'(empty),     int'(m_fifo.size() == 0));
        chk("rd_data",   int'(rd_data),   (m_fifo.size() > 0) ? m_fifo[0] : 0);
        chk("irq",       int'(irq),       int'(m_fifo.size() >= THRESH));
        chk("ovf",       int'(ovf),       int'(m_ovf));
        chk("busy",      int'(busy),      int'(m_enc.size() > 0));
        chk("key_clear", int'(key_clear), int'(m_kc));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            cyc();
            n++;
        end
        if (busy) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic snap(input logic [15:0] v);
        key_data = v;
        enable   = 1'b1;
        cyc();
        key_data = '0;
        wait_idle();
    endtask

    task automatic expect_pop(input int code);
        chk("pop_not_empty", int'(empty), 0);
        chk("pop_code", int'(rd_data), code);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_key_clear", int'(key_clear), 0);
        rst = 1'b0;

        // single key: clear strobe at t+1, code visible at t+2
        key_data = 16'h0004;
        enable   = 1'b1;
        cyc();
        key_data = '0;
        chk("t1_key_clear", int'(key_clear), 1);
        chk("t1_busy", int'(busy), 1);
        cyc();
        chk("t2_key_clear", int'(key_clear), 0);
        chk("t2_rd_data", int'(rd_data), 2);
        chk("t2_count", int'(count), 1);
        chk("t2_irq", int'(irq), 1);
        chk("t2_busy", int'(busy), 0);
        expect_pop(2);

        // pointer back to 15 after reset: 0, 8, 15 then 0, 1
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        snap(16'h8101);
        chk("rr_count3", int'(count), 3);
        expect_pop(0);
        expect_pop(8);
        expect_pop(15);
        snap(16'h0003);
        expect_pop(0);
        expect_pop(1);

        // rotation: after grant 8, 0301 -> 9, 0, 8
        snap(16'h0100);
        expect_pop(8);
        snap(16'h0301);
        expect_pop(9);
        expect_pop(0);
        expect_pop(8);
        chk("rr_drained", int'(count), 0);

        // overflow with a nearly-full FIFO
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        snap(16'h007F);
        chk("prefill_count", int'(count), 7);
        key_data = 16'h000F;
        cyc();
        key_data = '0;
        cyc();
        chk("ovf_first_count", int'(count), 8);
        chk("ovf_first_flag", int'(ovf), 0);
        cyc();
        chk("ovf_second_flag", int'(ovf), 1);
        wait_idle();
        chk("ovf_full_count", int'(count), 8);
        chk("ovf_head", int'(rd_data), 0);
        ovf_clr = 1'b1;
        cyc();
        chk("ovf_cleared", int'(ovf), 0);
        snap(16'h0003);
        chk("ovf_set_wins", int'(ovf), 1);
        cyc();
        ovf_clr = 1'b0;
        chk("ovf_cleared2", int'(ovf), 0);

        // push while full with a simultaneous read
        key_data = 16'h0010;
        cyc();
        key_data = '0;
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("full_rw_count", int'(count), 8);
        chk("full_rw_ovf", int'(ovf), 0);
        chk("full_rw_busy", int'(busy), 0);
        expect_pop(1);
        expect_pop(2);
        expect_pop(3);
        expect_pop(4);
        expect_pop(5);
        expect_pop(6);
        expect_pop(0);
        expect_pop(4);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("empty_read_count", int'(count), 0);
        chk("empty_read_empty", int'(empty), 1);

        // reset in the middle of an encode
        key_data = 16'h00F0;
        cyc();
        key_data = '0;
        cyc();
        chk("mid_busy", int'(busy), 1);
        chk("mid_count", int'(count), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_key_clear", int'(key_clear), 0);
        enable   = 1'b0;
        key_data = 16'hFFFF;
        repeat (3) cyc();
        chk("dis_key_clear", int'(key_clear), 0);
        chk("dis_count", int'(count), 0);
        key_data = '0;

        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            key_data = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0;
            rd_en    = ($urandom_range(0, 9) < 3);
            ovf_clr  = ($urandom_range(0, 19) == 0);
            cyc();
        end
        rd_en = 1'b0;
        key_data = '0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
